moving_average_filter: RTL and testbench

// Parametrised boxcar low-pass filter: running mean over the last 2**DEPTH_LOG2 signed samples.

---
 rtl/moving_average_filter_if.sv | 63 ++++++
 rtl/moving_average_filter.sv | 208 ++++++++++++++++++++
 tb/tb_moving_average_filter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/moving_average_filter_if.sv
// -----------------------------------------------------------------------------
// moving_average_filter_if
//
// Purpose
//   Bundles the sample-stream handshake of the moving-average filter: the
//   input valid/ready/data channel, the output valid/ready/data channel, the
//   synchronous flush control and the window-primed flag.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
// Parameters
//   DATA_W     sample width, two's-complement signed. It must match the
//              DATA_W of the filter instance this interface connects to.
//
// Signals
//   flush      source -> filter  synchronous clear of history, sum and fill count
//   in_valid   source -> filter  in_data valid this cycle
//   in_ready   filter -> source  filter accepts in_data this cycle
//   in_data    source -> filter  input sample (signed)
//   out_valid  filter -> sink    out_data valid
//   out_ready  sink   -> filter  sink accepts out_data
//   out_data   filter -> sink    filtered sample (signed)
//   primed     filter -> sink    out_data averages a full window of real samples
//
// Modports
//   master     the environment side: drives the source and sink controls
//   slave      the filter side
// -----------------------------------------------------------------------------
interface moving_average_filter_if #(
  parameter int DATA_W = 16
);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     primed;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  primed
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output primed
  );

endinterface : moving_average_filter_if

// File: rtl/moving_average_filter.sv
// -----------------------------------------------------------------------------
// moving_average_filter
//
// Purpose
//   Boxcar low-pass filter. Produces the running mean of the last
//   N = 2**DEPTH_LOG2 signed samples. Sits between the sample source
//   (mic/ADC front end) and the voice-classification logic.
//
//   Each accepted sample updates a running sum in one cycle:
//     sum_next = sum + in_data - hist[wr_ptr]
//   and overwrites the oldest history slot. The mean is sum_next scaled down
//   by N and is presented one cycle after the accept in a single output
//   register. Until N samples have arrived the empty slots read as zero, so
//   the first outputs ramp towards the input level; primed marks the outputs
//   that average a full window.
//
// Parameters
//   DATA_W       sample width, two's-complement signed (8..32)
//   DEPTH_LOG2   log2 of window length N (1..6)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          moving_average_filter_if.slave:
//                  flush, in_valid, in_data, out_ready   (inputs)
//                  in_ready, out_valid, out_data, primed (outputs)
//
// Build option
//   MAVG_ROUND_EN  defined   : mean rounded half up, clamped to DATA_W range
//                  undefined : mean is the floor (plain arithmetic shift)
//   Latency and handshake are the same in both builds.
// -----------------------------------------------------------------------------
module moving_average_filter #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  moving_average_filter_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int N     = 1 << DEPTH_LOG2;
  // N samples of DATA_W bits sum into DATA_W+DEPTH_LOG2 bits without overflow.
  localparam int SUM_W = DATA_W + DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   FILL_LAST = (DEPTH_LOG2 + 1)'(N - 1);

  typedef enum logic {
    S_FILL,   // fewer than N samples since reset/flush
    S_RUN     // window holds N real samples
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                   r_state;
  logic signed [DATA_W-1:0] r_hist [N];
  logic signed [SUM_W-1:0]  r_sum;
  logic [DEPTH_LOG2-1:0]    r_wr_ptr;
  logic [DEPTH_LOG2:0]      r_fill_cnt;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_primed;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_in_ready;
  logic w_accept;

  // The single output register may be refilled when it is empty or being
  // drained this cycle. flush blocks the input so a coincident sample is not
  // consumed.
  assign w_in_ready = ~bus.flush & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // ---------------------------------------------------------------------------
  // Running sum
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] w_in_ext;
  logic signed [SUM_W-1:0] w_old_ext;
  logic signed [SUM_W-1:0] w_sum_next;

  assign w_in_ext   = {{DEPTH_LOG2{bus.in_data[DATA_W-1]}}, bus.in_data};
  assign w_old_ext  = {{DEPTH_LOG2{r_hist[r_wr_ptr][DATA_W-1]}}, r_hist[r_wr_ptr]};
  assign w_sum_next = r_sum + w_in_ext - w_old_ext;

  // ---------------------------------------------------------------------------
  // Mean
  // ---------------------------------------------------------------------------
  // Dropping the low DEPTH_LOG2 bits of a two's-complement value is an
  // arithmetic shift right, i.e. floor division by N. The mean of N DATA_W
  // samples always fits DATA_W bits, so the upper slice is exact.
  logic signed [DATA_W-1:0] w_floor;
  logic signed [DATA_W-1:0] w_avg;

  assign w_floor = w_sum_next[SUM_W-1:DEPTH_LOG2];

`ifdef MAVG_ROUND_EN
  // floor((s + N/2) / N) equals floor(s / N) plus the bit just below the
  // binary point, so round-half-up is a one-bit increment of the floor,
  // computed one bit wider and clamped to the positive limit. Rounding only
  // ever moves the value upwards, so the negative limit cannot be exceeded.
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W:0] w_rnd_q;

  assign w_rnd_q = {w_floor[DATA_W-1], w_floor}
                 + {{DATA_W{1'b0}}, w_sum_next[DEPTH_LOG2-1]};
  assign w_avg   = (w_rnd_q[DATA_W] != w_rnd_q[DATA_W-1]) ? DATA_MAX
                                                           : w_rnd_q[DATA_W-1:0];
`else
  assign w_avg = w_floor;
`endif

  // ---------------------------------------------------------------------------
  // Window fill tracking
  // ---------------------------------------------------------------------------
  logic w_fill_done;
  logic w_next_primed;

  // The accept that brings the fill count to N completes the first full window.
  assign w_fill_done   = (r_state == S_FILL) && (r_fill_cnt == FILL_LAST);
  assign w_next_primed = (r_state == S_RUN) | w_fill_done;

  // ---------------------------------------------------------------------------
  // Sequential logic: history, sum, pointer, FSM and output register
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking assignments here would
  // make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the history array is reset on purpose: empty slots must read as
      // zero for the warm-up ramp and for flush, so it cannot be left to power-up
      // contents and therefore maps to flops, not a RAM macro.
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_state     <= S_FILL;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_primed    <= 1'b0;
    end else if (bus.flush) begin
      // Synchronous return to the reset state; a pending output is dropped.
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_state     <= S_FILL;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_primed    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hist[r_wr_ptr] <= bus.in_data;
        r_sum            <= w_sum_next;
        // Power-of-two depth: the pointer wraps N-1 -> 0 by natural overflow.
        r_wr_ptr         <= r_wr_ptr + PTR_ONE;

        case (r_state)
          S_FILL: begin
            r_fill_cnt <= r_fill_cnt + CNT_ONE;
            if (w_fill_done) begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            // Holds until flush or reset.
            r_state <= S_RUN;
          end
          default: begin
            r_state <= S_FILL;
          end
        endcase

        // primed is registered with the sample it qualifies.
        r_out_valid <= 1'b1;
        r_out_data  <= w_avg;
        r_primed    <= w_next_primed;
      end else if (bus.out_ready) begin
        // Output consumed with nothing to replace it. out_data and primed keep
        // their last values; they are only meaningful while out_valid is high.
        r_out_valid <= 1'b0;
      end
      // Otherwise out_valid & ~out_ready: the output register holds.
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.primed    = r_primed;

endmodule : moving_average_filter

// File: tb/tb_moving_average_filter.sv
// -----------------------------------------------------------------------------
// tb_moving_average_filter
//
// Directed bench for moving_average_filter with DATA_W = 16, DEPTH_LOG2 = 2
// (window N = 4). Expected values are worked out by hand from the window
// contents; where the floor and round-half-up builds differ, the expectation
// is selected with MAVG_ROUND_EN.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge, or 1 ns after an input change for the combinational in_ready.
// -----------------------------------------------------------------------------
module tb_moving_average_filter;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 2;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fails;

  moving_average_filter_if #(.DATA_W(DATA_W)) bus ();

  moving_average_filter #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one sample with out_ready=1, let it be accepted at the next rising
  // edge and check the registered result. in_valid stays high afterwards so
  // consecutive calls stream one sample per clock.
  task automatic send(input logic signed [DATA_W-1:0] d, input int exp_d,
                      input int exp_p, input string tag);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    #1;
    check({tag, ".in_ready"}, int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, int'(bus.out_valid), 1);
    check({tag, ".out_data"},  int'(bus.out_data),  exp_d);
    check({tag, ".primed"},    int'(bus.primed),    exp_p);
  endtask

  // One cycle with no input and out_ready=1: the output must drain.
  task automatic idle(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst.out_valid", int'(bus.out_valid), 0);
    check("rst.out_data",  int'(bus.out_data),  0);
    check("rst.primed",    int'(bus.primed),    0);
    check("rst.in_ready",  int'(bus.in_ready),  1);
    do_reset();

    // 1 Ramp: 100 x5 -> 25,50,75,100,100
    send(16'sd100,  25, 0, "ramp0");
    send(16'sd100,  50, 0, "ramp1");
    send(16'sd100,  75, 0, "ramp2");
    send(16'sd100, 100, 1, "ramp3");
    send(16'sd100, 100, 1, "ramp4");
    idle("ramp_drain");

    // 2 Step down: 0 x4 -> 75,50,25,0, primed stays 1
    send(16'sd0, 75, 1, "step0");
    send(16'sd0, 50, 1, "step1");
    send(16'sd0, 25, 1, "step2");
    send(16'sd0,  0, 1, "step3");

    // 5 Flush with coincident sample 400: not consumed, state cleared
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd400;
    #1;
    check("flush.in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("flush.out_valid", int'(bus.out_valid), 0);
    check("flush.primed",    int'(bus.primed),    0);
    check("flush.out_data",  int'(bus.out_data),  0);
    // 400 consumed would give (400+40)/4 = 110
    send(16'sd40, 10, 0, "post_flush");
    idle("flush_drain");

    // 3 Signed / rounding, then negative extreme
    do_reset();
`ifdef MAVG_ROUND_EN
    send(-16'sd1,       0,      0, "neg0");
    send(-16'sd32768,  -8192,   0, "neg1");
    send(-16'sd32768,  -16384,  0, "neg2");
    send(-16'sd32768,  -24576,  1, "neg3");
`else
    send(-16'sd1,      -1,      0, "neg0");
    send(-16'sd32768,  -8193,   0, "neg1");
    send(-16'sd32768,  -16385,  0, "neg2");
    send(-16'sd32768,  -24577,  1, "neg3");
`endif
    send(-16'sd32768, -32768, 1, "neg_min");
    // Positive extreme replaces the window one sample at a time
`ifdef MAVG_ROUND_EN
    send(16'sd32767, -16384, 1, "pos0");
    send(16'sd32767,  0,     1, "pos1");
`else
    send(16'sd32767, -16385, 1, "pos0");
    send(16'sd32767, -1,     1, "pos1");
`endif
    send(16'sd32767, 16383, 1, "pos2");
    send(16'sd32767, 32767, 1, "pos_max");
    idle("ext_drain");

    // 4 Backpressure: 8 per clock, out_ready=0 for 3 clocks after first output
    do_reset();
    send(16'sd8, 2, 0, "bp0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      check("bp_stall.in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check("bp_stall.out_valid", int'(bus.out_valid), 1);
      check("bp_stall.out_data",  int'(bus.out_data),  2);
      check("bp_stall.primed",    int'(bus.primed),    0);
    end
    send(16'sd8, 4, 0, "bp1");
    send(16'sd8, 6, 0, "bp2");
    send(16'sd8, 8, 1, "bp3");
    idle("bp_drain");

    // 6 Async reset mid-burst, between clock edges
    do_reset();
    send(16'sd100, 25, 0, "arst_pre0");
    send(16'sd100, 50, 0, "arst_pre1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", int'(bus.out_valid), 0);
    check("arst.primed",    int'(bus.primed),    0);
    check("arst.out_data",  int'(bus.out_data),  0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    send(16'sd100,  25, 0, "restart0");
    send(16'sd100,  50, 0, "restart1");
    send(16'sd100,  75, 0, "restart2");
    send(16'sd100, 100, 1, "restart3");
    send(16'sd100, 100, 1, "restart4");
    idle("restart_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_moving_average_filter
